// File: rtl/fgen_sequencer.sv
// Profile sequencer for the FunctionGenerator: steps a table of waveform entries and applies
// each one only at a waveform period boundary. Optional looping is enabled by SEQ_LOOP_EN.
module fgen_sequencer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned DWELL_W  = 16,
    localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
    input  logic                clk_50,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [2:0]          wr_status,
    input  logic [1:0]          wr_amp,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [DWELL_W-1:0]  wr_dwell,
    input  logic [IDX_W-1:0]    last_idx,
    input  logic                start,
    input  logic                stop,
    input  logic                wrap_pulse,
`ifdef SEQ_LOOP_EN
    input  logic                loop,
`endif
    output logic [2:0]          status,
    output logic [1:0]          ampSelect,
    output logic [PERIOD_W-1:0] setPeriod,
    output logic [IDX_W-1:0]    cur_idx,
    output logic                cfg_update,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

    logic [2:0]          status_mem [DEPTH];
    logic [1:0]          amp_mem    [DEPTH];
    logic [PERIOD_W-1:0] period_mem [DEPTH];
    logic [DWELL_W-1:0]  dwell_mem  [DEPTH];

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic [2:0]          status_q, status_d;
    logic [1:0]          amp_q, amp_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                cfg_update_q, cfg_update_d;

    logic                ld_en;
    logic [IDX_W-1:0]    ld_idx;
    logic                tbl_open;

    assign tbl_open = (state_q == StIdle) || (state_q == StDone);

    // Table is deliberately not reset; it survives rst so a profile need not be reloaded.
    always_ff @(posedge clk_50) begin
        if (wr_en && tbl_open) begin
            status_mem[wr_addr] <= wr_status;
            amp_mem[wr_addr]    <= wr_amp;
            period_mem[wr_addr] <= wr_period;
            dwell_mem[wr_addr]  <= wr_dwell;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cur_idx_d    = cur_idx_q;
        status_d     = status_q;
        amp_d        = amp_q;
        period_d     = period_q;
        dwell_d      = dwell_q;
        cfg_update_d = 1'b0;
        ld_en        = 1'b0;
        ld_idx       = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start && stop) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d   = StArm;
                    last_d    = last_idx;
                    cur_idx_d = '0;
                end
            end
            StArm: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (wrap_pulse) begin
                    state_d = StRun;
                    ld_en   = 1'b1;
                    ld_idx  = '0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (wrap_pulse) begin
                    if (dwell_q > DWELL_W'(1)) begin
                        dwell_d = dwell_q - 1'b1;
                    end else if (cur_idx_q != last_q) begin
                        ld_en  = 1'b1;
                        ld_idx = cur_idx_q + 1'b1;
                    end else begin
`ifdef SEQ_LOOP_EN
                        if (loop) begin
                            ld_en  = 1'b1;
                            ld_idx = '0;
                        end else begin
                            state_d = StDone;
                        end
`else
                        state_d = StDone;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (ld_en) begin
            cur_idx_d    = ld_idx;
            status_d     = status_mem[ld_idx];
            amp_d        = amp_mem[ld_idx];
            period_d     = period_mem[ld_idx];
            // A zero dwell still holds the entry for one full period.
            dwell_d      = (dwell_mem[ld_idx] == '0) ? DWELL_W'(1) : dwell_mem[ld_idx];
            cfg_update_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_q       <= '0;
            cur_idx_q    <= '0;
            status_q     <= 3'd1;
            amp_q        <= 2'd0;
            period_q     <= PERIOD_W'(25);
            dwell_q      <= '0;
            cfg_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cur_idx_q    <= cur_idx_d;
            status_q     <= status_d;
            amp_q        <= amp_d;
            period_q     <= period_d;
            dwell_q      <= dwell_d;
            cfg_update_q <= cfg_update_d;
        end
    end

    assign status     = status_q;
    assign ampSelect  = amp_q;
    assign setPeriod  = period_q;
    assign cur_idx    = cur_idx_q;
    assign cfg_update = cfg_update_q;
    assign busy       = (state_q == StArm) || (state_q == StRun);
    assign done       = (state_q == StDone);

endmodule

// File: doc/fgen_sequencer.md
Name: fgen_sequencer

Overview:
Profile sequencer for the FunctionGenerator datapath. It holds a small table of waveform entries, each made of waveform select, amplitude select, period and dwell. It steps through the table and drives the generator's status, ampSelect and setPeriod inputs. Changes are applied only at a waveform period boundary, signalled by wrap_pulse from the generator, so the output waveform never glitches mid-period.

Parameters:
DEPTH, 8, number of profile entries (power of two; index width IDX_W = log2(DEPTH)).
PERIOD_W, 8, width of the setPeriod field.
DWELL_W, 16, width of the dwell field, counted in waveform periods.

Ports:
clk_50  in  1  system clock; all logic is rising-edge.
rst  in  1  asynchronous, active-low reset.
wr_en  in  1  table write strobe.
wr_addr  in  IDX_W  table entry index.
wr_status  in  3  waveform select for the entry.
wr_amp  in  2  amplitude select for the entry.
wr_period  in  PERIOD_W  period for the entry.
wr_dwell  in  DWELL_W  number of waveform periods to hold the entry.
last_idx  in  IDX_W  index of the final entry; sampled on start.
start  in  1  one-cycle pulse that begins a sequence.
stop  in  1  one-cycle pulse that aborts a sequence.
wrap_pulse  in  1  one-cycle pulse from the generator at the end of each waveform period.
status  out  3  waveform select to the generator.
ampSelect  out  2  amplitude select to the generator.
setPeriod  out  PERIOD_W  period to the generator.
cur_idx  out  IDX_W  index of the entry currently applied.
cfg_update  out  1  one-cycle strobe, high in the same cycle the new outputs first appear.
busy  out  1  high in ARM and RUN.
done  out  1  level; high in DONE.

Behaviour:
- Reset values (rst low, asynchronous):
  - status=1, ampSelect=0, setPeriod=25, cur_idx=0.
  - cfg_update=0, busy=0, done=0, state=IDLE.
  - Table contents are not reset.
- Table writes:
  - Accepted only in IDLE and DONE.
  - wr_en in ARM or RUN is ignored; the table is unchanged.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE/DONE:
  - start -> ARM.
  - Latch last_idx; set cur_idx=0; clear done.
- ARM:
  - Wait for wrap_pulse.
  - On wrap_pulse: the next cycle loads entry 0 onto the outputs, asserts cfg_update for that cycle, loads dwell_cnt = max(dwell,1), and enters RUN.
- RUN, on each wrap_pulse:
  - If dwell_cnt > 1: decrement dwell_cnt.
  - If dwell_cnt == 1 and cur_idx != latched last_idx: cur_idx+1; load that entry; cfg_update pulse; reload dwell_cnt.
  - If dwell_cnt == 1 and cur_idx == latched last_idx: enter DONE (loop behaviour is under Optional Feature). Outputs hold the last entry; done=1; busy=0; no cfg_update.
- Latency: outputs change exactly 1 cycle after the qualifying wrap_pulse. Two entries are never applied within one waveform period.
- Dwell of 0 is treated as 1.
- last_idx greater than DEPTH-1 is impossible by width.
- stop:
  - In ARM or RUN: the next cycle enters IDLE with busy=0 and done=0.
  - Outputs and cur_idx hold their current values.
  - stop takes priority over a simultaneous wrap_pulse; no load occurs.
- start:
  - Ignored while busy.
  - start and stop in the same cycle in IDLE/DONE: stop wins and the block stays in IDLE.
- wr_en and start in the same cycle: the write completes, and the sequence reads the updated table.
- rst asserted mid-sequence: immediate return to reset values; the table is kept.

Optional Feature:
Macro SEQ_LOOP_EN.
- Defined: adds input port loop (1 bit), sampled at the final entry's last wrap_pulse.
  - loop=1: cur_idx wraps to 0, entry 0 loads with cfg_update, and the block stays in RUN.
  - loop=0: the block enters DONE.
- Undefined: no loop port; sequences are always one-shot and end in DONE.

Test Plan:
- Reset values: hold rst low, then release -> status=1, ampSelect=0, setPeriod=25, busy=0, done=0, cfg_update=0.
- Basic sequence:
  - Setup: write entry0 {status=2, amp=1, period=40, dwell=2} and entry1 {status=3, amp=3, period=10, dwell=1}; last_idx=1; start; issue wrap_pulse every 20 cycles.
  - Required: after the 1st wrap, outputs are entry0 with cfg_update.
  - After the 3rd wrap, outputs are entry1.
  - After the 4th wrap, done=1 and outputs still show entry1.
- Stop handling: stop asserted in the same cycle as a wrap_pulse that would advance -> no cfg_update, IDLE, outputs unchanged, busy=0.
- Write lock: wr_en to entry0 with period=99 during RUN -> ignored. Restart after DONE -> setPeriod=40 applied.
- Zero dwell: entry0 dwell=0, last_idx=0 -> entry0 applied at the 1st wrap; DONE at the 2nd wrap.
- Looping (SEQ_LOOP_EN defined): loop=1 with 2 entries -> cur_idx sequence 0,1,0,1 with cfg_update at each change and done never set. Then loop=0 -> DONE after entry1 completes.
